// File: rtl/mc_decode_fsm.sv
// Multicycle instruction decoder: Moore FSM driving the shared datapath and an iterative multiplier.
// Optional `DECODE_ILLEGAL_TRAP_EN sends illegal decodes to a TRAP state with an Illegal output.
module mc_decode_fsm #(
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned CNT_W      = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  Op,
    input  logic [5:0]  Funct,
    input  logic [3:0]  Rd,
    input  logic [11:0] Src2,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic        NextPC,
    output logic        Branch,
    output logic        RegW,
    output logic        MemW,
    output logic [1:0]  FlagW,
    output logic [3:0]  DPUSControl,
    output logic        Mul,
    output logic        MulStart,
    output logic        AuxSel,
    output logic        PCS,
    output logic        Busy
`ifdef DECODE_ILLEGAL_TRAP_EN
    ,
    output logic        Illegal
`endif
);

    typedef enum logic [3:0] {
        StFetch, StDecode, StMemAdr, StMemRd, StMemWb, StMemWr, StExecR, StExecI,
        StAluWb, StBranch, StMulEx, StMulWbLo, StMulWbHi, StTrap
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       is_mul, dp_ok, mul_ok, long_mul, illegal, flag_cv, cnt_last;
    logic [3:0] dp_ctrl, mul_ctrl, dec_ctrl;
    logic       unused_src2;

    assign unused_src2 = ^{Src2[11:8], Src2[3:0]};

    // Instruction decode; fields come straight from the instruction register.
    assign is_mul = (Op == 2'b00) && (Src2[7:4] == 4'b1001);

    always_comb begin
        dp_ok   = 1'b1;
        dp_ctrl = 4'b0000;
        case (Funct[4:1])
            4'b0100: dp_ctrl = 4'b0000;
            4'b0010: dp_ctrl = 4'b0001;
            4'b0000: dp_ctrl = 4'b0010;
            4'b1100: dp_ctrl = 4'b0011;
            4'b1010: dp_ctrl = 4'b1010;
            4'b1011: dp_ctrl = 4'b1000;
            default: dp_ok   = 1'b0;
        endcase
    end

    always_comb begin
        mul_ok   = 1'b1;
        mul_ctrl = 4'b0000;
        case (Funct[3:1])
            3'b000:  mul_ctrl = 4'b0100;
            3'b100:  mul_ctrl = 4'b0101;
            3'b110:  mul_ctrl = 4'b0111;
            3'b101:  mul_ctrl = 4'b1011;
            3'b111:  mul_ctrl = 4'b1001;
            default: mul_ok   = 1'b0;
        endcase
    end

    assign long_mul = (Funct[3:1] == 3'b100) || (Funct[3:1] == 3'b110);
    assign illegal  = (Op == 2'b11) || ((Op == 2'b00) && (is_mul ? !mul_ok : !dp_ok));
    assign dec_ctrl = is_mul ? mul_ctrl : ((Op == 2'b00) ? dp_ctrl : 4'b0000);
    assign flag_cv  = (dp_ctrl == 4'b0000) || (dp_ctrl == 4'b0001) ||
                      (dp_ctrl == 4'b1000) || (dp_ctrl == 4'b1010);
    assign cnt_last = (cnt_q == CNT_W'(MUL_CYCLES - 1));

    // Counter runs only while in MULEX, so it is zero on every entry.
    assign cnt_d = (state_q == StMulEx) ? cnt_q + CNT_W'(1) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch:  state_d = StDecode;
            StDecode: begin
                if (illegal) begin
`ifdef DECODE_ILLEGAL_TRAP_EN
                    state_d = StTrap;
`else
                    state_d = StFetch;
`endif
                end else if (Op == 2'b00) begin
                    state_d = is_mul ? StMulEx : (Funct[5] ? StExecI : StExecR);
                end else if (Op == 2'b01) begin
                    state_d = StMemAdr;
                end else begin
                    state_d = StBranch;
                end
            end
            StMemAdr:  state_d = Funct[0] ? StMemRd : StMemWr;
            StMemRd:   state_d = StMemWb;
            StMemWb:   state_d = StFetch;
            StMemWr:   state_d = StFetch;
            StExecR:   state_d = StAluWb;
            StExecI:   state_d = StAluWb;
            StAluWb:   state_d = StFetch;
            StBranch:  state_d = StFetch;
            StMulEx:   state_d = cnt_last ? StMulWbLo : StMulEx;
            StMulWbLo: state_d = long_mul ? StMulWbHi : StFetch;
            StMulWbHi: state_d = StFetch;
`ifdef DECODE_ILLEGAL_TRAP_EN
            StTrap:    state_d = StTrap;
`endif
            default:   state_d = StFetch;
        endcase
    end

    always_comb begin
        IRWrite     = 1'b0;
        AdrSrc      = 1'b0;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        ResultSrc   = 2'b00;
        ImmSrc      = 2'b00;
        RegSrc      = 2'b00;
        NextPC      = 1'b0;
        Branch      = 1'b0;
        RegW        = 1'b0;
        MemW        = 1'b0;
        FlagW       = 2'b00;
        DPUSControl = 4'b0000;
        Mul         = 1'b0;
        MulStart    = 1'b0;
        AuxSel      = 1'b0;
        PCS         = 1'b0;
        Busy        = 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
        Illegal     = 1'b0;
`endif
        if (!reset) begin
            // Decoded fields are valid from DECODE until the instruction retires.
            if (state_q != StFetch) begin
                Busy        = 1'b1;
                DPUSControl = dec_ctrl;
                RegSrc      = {Op == 2'b01, Op == 2'b10};
                ImmSrc      = (Op == 2'b11) ? 2'b00 : Op;
            end
            case (state_q)
                StFetch: begin
                    IRWrite   = 1'b1;
                    ALUSrcA   = 2'b01;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                    NextPC    = 1'b1;
                end
                StDecode: begin
                    ALUSrcA   = 2'b01;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                end
                StMemAdr: ALUSrcB = 2'b01;
                StMemRd:  AdrSrc  = 1'b1;
                StMemWb: begin
                    ResultSrc = 2'b01;
                    RegW      = 1'b1;
                end
                StMemWr: begin
                    AdrSrc = 1'b1;
                    MemW   = 1'b1;
                end
                StExecR: FlagW = {Funct[0], Funct[0] & flag_cv};
                StExecI: begin
                    FlagW   = {Funct[0], Funct[0] & flag_cv};
                    ALUSrcB = 2'b01;
                end
                StAluWb: RegW = 1'b1;
                StBranch: begin
                    ALUSrcB   = 2'b01;
                    ResultSrc = 2'b10;
                    Branch    = 1'b1;
                end
                StMulEx: begin
                    Mul      = 1'b1;
                    MulStart = (cnt_q == '0);
                    FlagW    = cnt_last ? {Funct[0], 1'b0} : 2'b00;
                end
                StMulWbLo: begin
                    RegW = 1'b1;
                    Mul  = 1'b1;
                end
                StMulWbHi: begin
                    RegW   = 1'b1;
                    Mul    = 1'b1;
                    AuxSel = 1'b1;
                end
`ifdef DECODE_ILLEGAL_TRAP_EN
                StTrap: Illegal = 1'b1;
`endif
                default: ;
            endcase
            PCS = (RegW && (Rd == 4'b1111)) || Branch;
        end
    end

endmodule

// File: tb/tb_mc_decode_fsm.sv
// Directed bench for mc_decode_fsm: walks each instruction class from FETCH back to FETCH
// and compares per-instruction summaries against hand-computed values.
module tb_mc_decode_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  Op;
    logic [5:0]  Funct;
    logic [3:0]  Rd;
    logic [11:0] Src2;
    logic        IRWrite, AdrSrc, NextPC, Branch, RegW, MemW, Mul, MulStart, AuxSel, PCS, Busy;
    logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc, FlagW;
    logic [3:0]  DPUSControl;
    logic [31:0] outs;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic        Illegal;
`endif

    int checks = 0;
    int errors = 0;

    int         r_cyc, r_regw, r_start, r_start_at, r_mulex, r_memw, r_branch, r_flag_at, r_pcs;
    logic [1:0] r_flagw, r_aux, r_res_wb, r_imm_br;
    logic [3:0] r_dpus_dec, r_dpus_last;

    always #5 clk = ~clk;

    mc_decode_fsm #(.MUL_CYCLES(4), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .Src2(Src2),
        .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .NextPC(NextPC),
        .Branch(Branch), .RegW(RegW), .MemW(MemW), .FlagW(FlagW),
        .DPUSControl(DPUSControl), .Mul(Mul), .MulStart(MulStart), .AuxSel(AuxSel),
        .PCS(PCS), .Busy(Busy)
`ifdef DECODE_ILLEGAL_TRAP_EN
        , .Illegal(Illegal)
`endif
    );

`ifdef DECODE_ILLEGAL_TRAP_EN
    assign outs = {4'd0, Illegal, IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc,
                   NextPC, Branch, RegW, MemW, FlagW, DPUSControl, Mul, MulStart, AuxSel, PCS,
                   Busy};
`else
    assign outs = {5'd0, IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc,
                   NextPC, Branch, RegW, MemW, FlagW, DPUSControl, Mul, MulStart, AuxSel, PCS,
                   Busy};
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [1:0] op, input logic [5:0] fn, input logic [3:0] rd,
                        input logic [11:0] s2);
        Op    = op;
        Funct = fn;
        Rd    = rd;
        Src2  = s2;
    endtask

    // Called while in FETCH; runs until FETCH is seen again (cycle 1 = FETCH).
    task automatic run_instr;
        r_cyc = 1;   r_regw = 0;  r_start = 0;  r_start_at = 0; r_mulex = 0;
        r_memw = 0;  r_branch = 0; r_flag_at = 0; r_pcs = 0;
        r_flagw = 0; r_aux = 0;   r_res_wb = 0; r_imm_br = 0;
        r_dpus_dec = 0; r_dpus_last = 0;
        step;
        while (Busy && r_cyc < 64) begin
            r_cyc++;
            if (r_cyc == 2) r_dpus_dec = DPUSControl;
            r_dpus_last = DPUSControl;
            if (RegW) begin
                r_regw++;
                r_aux    = {r_aux[0], AuxSel};
                r_res_wb = ResultSrc;
            end
            if (MulStart) begin
                r_start++;
                r_start_at = r_cyc;
            end
            if (Mul && !RegW) r_mulex++;
            if (MemW) r_memw++;
            if (Branch) begin
                r_branch++;
                r_imm_br = ImmSrc;
            end
            if (FlagW != 2'b00) begin
                r_flagw   = FlagW;
                r_flag_at = r_cyc;
            end
            if (PCS) r_pcs++;
            step;
        end
        check("back_to_fetch", Busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        load(2'b00, 6'd0, 4'd0, 12'd0);
        step;
        step;
        check("rst_outs", outs, 0);
        reset = 1'b0;
        #1;
        check("fetch_irwrite", IRWrite, 1);
        check("fetch_busy", Busy, 0);
        check("fetch_srcs", {ALUSrcA, ALUSrcB, ResultSrc, NextPC}, 7'b01_10_10_1);

        // ADD immediate with S
        load(2'b00, 6'b001001, 4'd1, 12'h000);
        run_instr;
        check("add_cyc", r_cyc, 4);
        check("add_dpus", r_dpus_dec, 4'b0000);
        check("add_flagw", r_flagw, 2'b11);
        check("add_flag_at", r_flag_at, 3);
        check("add_regw", r_regw, 1);
        check("add_res_wb", r_res_wb, 2'b00);
        check("add_pcs", r_pcs, 0);

        // SUB register with S
        load(2'b00, 6'b000101, 4'd2, 12'h000);
        run_instr;
        check("sub_cyc", r_cyc, 4);
        check("sub_dpus", r_dpus_dec, 4'b0001);
        check("sub_flagw", r_flagw, 2'b11);

        // AND with S writing R15: no CV save, PC-affecting write
        load(2'b00, 6'b000001, 4'hF, 12'h000);
        run_instr;
        check("and_dpus", r_dpus_dec, 4'b0010);
        check("and_flagw", r_flagw, 2'b10);
        check("and_pcs", r_pcs, 1);

        // MUL
        load(2'b00, 6'b000000, 4'd2, 12'h090);
        run_instr;
        check("mul_cyc", r_cyc, 7);
        check("mul_start", r_start, 1);
        check("mul_start_at", r_start_at, 3);
        check("mul_mulex", r_mulex, 4);
        check("mul_regw", r_regw, 1);
        check("mul_aux", r_aux, 2'b00);
        check("mul_dpus", r_dpus_dec, 4'b0100);
        check("mul_flagw", r_flagw, 2'b00);

        // UMULL with S (same Funct as the ADD above, but Src2[7:4]=1001)
        load(2'b00, 6'b001001, 4'd4, 12'h090);
        run_instr;
        check("umull_cyc", r_cyc, 8);
        check("umull_dpus", r_dpus_dec, 4'b0101);
        check("umull_dpus_hold", r_dpus_last, 4'b0101);
        check("umull_flagw", r_flagw, 2'b10);
        check("umull_flag_at", r_flag_at, 6);
        check("umull_regw", r_regw, 2);
        check("umull_aux", r_aux, 2'b01);
        check("umull_mulex", r_mulex, 4);

        // MULL16: single writeback
        load(2'b00, 6'b001110, 4'd5, 12'h090);
        run_instr;
        check("mull16_cyc", r_cyc, 7);
        check("mull16_dpus", r_dpus_dec, 4'b1001);
        check("mull16_regw", r_regw, 1);

        // LDR into PC
        load(2'b01, 6'b011001, 4'hF, 12'h004);
        run_instr;
        check("ldr_cyc", r_cyc, 5);
        check("ldr_regw", r_regw, 1);
        check("ldr_res_wb", r_res_wb, 2'b01);
        check("ldr_pcs", r_pcs, 1);
        check("ldr_memw", r_memw, 0);

        // STR
        load(2'b01, 6'b011000, 4'd3, 12'h004);
        run_instr;
        check("str_cyc", r_cyc, 4);
        check("str_memw", r_memw, 1);
        check("str_regw", r_regw, 0);

        // B
        load(2'b10, 6'b100000, 4'd0, 12'h010);
        run_instr;
        check("b_cyc", r_cyc, 3);
        check("b_branch", r_branch, 1);
        check("b_pcs", r_pcs, 1);
        check("b_immsrc", r_imm_br, 2'b10);

        // Reset in the second MULEX cycle aborts the multiply
        load(2'b00, 6'b000000, 4'd6, 12'h090);
        step;
        step;
        step;
        check("mid_mulex2", {Mul, MulStart}, 2'b10);
        reset = 1'b1;
        #1;
        check("mid_rst_outs", outs, 0);
        step;
        check("mid_rst_fetch_outs", outs, 0);
        reset = 1'b0;
        #1;
        check("mid_post_irwrite", IRWrite, 1);
        check("mid_post_busy", Busy, 0);
        run_instr;
        check("mid_rerun_cyc", r_cyc, 7);
        check("mid_rerun_regw", r_regw, 1);
        check("mid_rerun_start_at", r_start_at, 3);

`ifdef DECODE_ILLEGAL_TRAP_EN
        load(2'b11, 6'b000000, 4'd1, 12'h000);
        step;
        step;
        for (int i = 0; i < 3; i++) begin
            check("trap_illegal", Illegal, 1);
            check("trap_busy", Busy, 1);
            check("trap_writes", {RegW, MemW, FlagW}, 4'b0000);
            step;
        end
        reset = 1'b1;
        step;
        reset = 1'b0;
        #1;
        check("trap_cleared", {Illegal, Busy, IRWrite}, 3'b001);
`else
        // Op=11 executes as NOP
        load(2'b11, 6'b000000, 4'd1, 12'h000);
        run_instr;
        check("op11_cyc", r_cyc, 2);
        check("op11_writes", {r_regw[3:0], r_memw[3:0], 2'b00, r_flagw}, 0);

        // Unlisted data-processing command executes as NOP
        load(2'b00, 6'b000011, 4'd1, 12'h000);
        run_instr;
        check("baddp_cyc", r_cyc, 2);
        check("baddp_writes", {r_regw[3:0], r_memw[3:0], 2'b00, r_flagw}, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
